// File: rtl/us_ip_tx.sv
// IPv4 transmit framer: prepends a 20-byte IPv4 header to a 64-bit AXIS payload
// stream and realigns the payload by 4 bytes behind the destination address.
module us_ip_tx #(
  parameter logic [7:0] TTL     = 8'hFF,
  parameter logic [7:0] TOS     = 8'h00,
  parameter logic       DF_FLAG = 1'b1
) (
  input  logic        tx_axis_aclk,
  input  logic        tx_axis_areset,
  input  logic [63:0] ip_tx_axis_tdata,
  input  logic [7:0]  ip_tx_axis_tkeep,
  input  logic        ip_tx_axis_tvalid,
  input  logic        ip_tx_axis_tlast,
  input  logic        ip_tx_axis_tuser,
  output logic        ip_tx_axis_tready,
  input  logic [15:0] ip_tx_length,
  input  logic [7:0]  ip_tx_protocol,
  input  logic [31:0] local_ip_addr,
  input  logic [31:0] dst_ip_addr,
  output logic [63:0] mac_tx_axis_tdata,
  output logic [7:0]  mac_tx_axis_tkeep,
  output logic        mac_tx_axis_tvalid,
  output logic        mac_tx_axis_tlast,
  output logic        mac_tx_axis_tuser,
  input  logic        mac_tx_axis_tready
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, PAY, TAIL} state_t;

  state_t      state, state_n;
  logic [15:0] len_r, id_r, id_cnt, csum_r, csum_n;
  logic [7:0]  proto_r;
  logic [31:0] src_r, dst_r, held_data;
  logic [3:0]  held_keep;
  logic        user_r;
  logic        adv, take, load, last_accept;
  logic [63:0] data_n;
  logic [7:0]  keep_n;
  logic        last_n, user_n;
  logic [15:0] totlen, flags;
  logic [31:0] sum0, sum1, sum2;

  // Addresses are held as {a,b,c,d}; lane 0 carries 'a' on the wire.
  function automatic logic [31:0] wire_order(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [63:0] mask_lanes(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
    return m;
  endfunction

  assign adv         = !mac_tx_axis_tvalid || mac_tx_axis_tready;
  assign take        = ip_tx_axis_tvalid && ip_tx_axis_tready;
  assign last_accept = mac_tx_axis_tvalid && mac_tx_axis_tready && mac_tx_axis_tlast;
  assign totlen      = len_r + 16'd20;
  assign flags       = {1'b0, DF_FLAG, 14'd0};

  always_comb begin
    sum0 = 32'({8'h45, TOS}) + 32'(totlen) + 32'(id_r) + 32'(flags)
         + 32'({TTL, proto_r}) + 32'(src_r[31:16]) + 32'(src_r[15:0])
         + 32'(dst_r[31:16]) + 32'(dst_r[15:0]);
    sum1 = {16'h0, sum0[15:0]} + {16'h0, sum0[31:16]};
    sum2 = {16'h0, sum1[15:0]} + {16'h0, sum1[31:16]};
    csum_n = ~sum2[15:0];
  end

  always_ff @(posedge tx_axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (tx_axis_areset) state <= IDLE;
    else                state <= state_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n           = state;
    ip_tx_axis_tready = 1'b0;
    load              = 1'b0;
    data_n            = '0;
    keep_n            = '0;
    last_n            = 1'b0;
    user_n            = 1'b0;
    unique case (state)
      IDLE: if (ip_tx_axis_tvalid && adv) state_n = HDR0;
      HDR0: if (adv) begin
        load    = 1'b1;
        data_n  = {flags[7:0], flags[15:8], id_r[7:0], id_r[15:8],
                   totlen[7:0], totlen[15:8], TOS, 8'h45};
        keep_n  = 8'hFF;
        state_n = HDR1;
      end
      HDR1: if (adv) begin
        load    = 1'b1;
        data_n  = {wire_order(src_r), csum_r[7:0], csum_r[15:8], proto_r, TTL};
        keep_n  = 8'hFF;
        state_n = HDR2;
      end
      HDR2: begin
        ip_tx_axis_tready = adv;
        if (ip_tx_axis_tvalid && adv) begin
          load   = 1'b1;
          data_n = {ip_tx_axis_tdata[31:0], wire_order(dst_r)};
          keep_n = {ip_tx_axis_tkeep[3:0], 4'hF};
          if (ip_tx_axis_tlast && ip_tx_axis_tkeep[7:4] == 4'h0) begin
            last_n  = 1'b1;
            user_n  = user_r || ip_tx_axis_tuser;
            state_n = IDLE;
          end else begin
            state_n = PAY;
          end
        end
      end
      PAY: begin
        ip_tx_axis_tready = adv;
        if (ip_tx_axis_tvalid && adv) begin
          load   = 1'b1;
          data_n = {ip_tx_axis_tdata[31:0], held_data};
          keep_n = {ip_tx_axis_tkeep[3:0], held_keep};
          if (ip_tx_axis_tlast) begin
            if (ip_tx_axis_tkeep[7:4] == 4'h0) begin
              last_n  = 1'b1;
              user_n  = user_r || ip_tx_axis_tuser;
              state_n = IDLE;
            end else begin
              state_n = TAIL;
            end
          end
        end
      end
      TAIL: if (adv) begin
        load    = 1'b1;
        data_n  = {32'h0, held_data};
        keep_n  = {4'h0, held_keep};
        last_n  = 1'b1;
        user_n  = user_r;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      mac_tx_axis_tdata  <= '0;
      mac_tx_axis_tkeep  <= '0;
      mac_tx_axis_tvalid <= 1'b0;
      mac_tx_axis_tlast  <= 1'b0;
      mac_tx_axis_tuser  <= 1'b0;
      id_cnt             <= '0;
      id_r               <= '0;
      len_r              <= '0;
      proto_r            <= '0;
      src_r              <= '0;
      dst_r              <= '0;
      csum_r             <= '0;
      held_data          <= '0;
      held_keep          <= '0;
      user_r             <= 1'b0;
    end else begin
      if (last_accept) id_cnt <= id_cnt + 16'd1;
      // A previous packet's tlast may be accepted in the very cycle the next one is captured.
      if (state == IDLE && ip_tx_axis_tvalid && adv) begin
        len_r   <= ip_tx_length;
        proto_r <= ip_tx_protocol;
        src_r   <= local_ip_addr;
        dst_r   <= dst_ip_addr;
        id_r    <= id_cnt + {15'd0, last_accept};
        user_r  <= 1'b0;
      end
      if (state == HDR0) csum_r <= csum_n;
      if (take) begin
        held_data <= ip_tx_axis_tdata[63:32];
        held_keep <= ip_tx_axis_tkeep[7:4];
        user_r    <= user_r || ip_tx_axis_tuser;
      end
      if (load) begin
        mac_tx_axis_tdata  <= mask_lanes(data_n, keep_n);
        mac_tx_axis_tkeep  <= keep_n;
        mac_tx_axis_tvalid <= 1'b1;
        mac_tx_axis_tlast  <= last_n;
        mac_tx_axis_tuser  <= user_n;
      end else if (adv) begin
        mac_tx_axis_tdata  <= '0;
        mac_tx_axis_tkeep  <= '0;
        mac_tx_axis_tvalid <= 1'b0;
        mac_tx_axis_tlast  <= 1'b0;
        mac_tx_axis_tuser  <= 1'b0;
      end
    end
  end

endmodule
